inst_fetch: RTL and testbench

Instruction fetch stage feeding the decode stage. Owns the PC and issues in-order fetch requests to instruction memory. Buffers returned instructions in a small FIFO and presents {InstAddrOut, InstOut} pairs to decode under valid/ready. Handles control-flow redirects by flushing buffered instructions and discarding stale in-flight responses.

---
 rtl/inst_fetch.sv | 96 +++++++++
 tb/tb_inst_fetch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner issuing in-order instruction fetches, buffering returned words for decode
// and discarding responses that belong to requests issued before a redirect.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        MemReqValid,
    output logic [63:0] MemReqAddr,
    input  logic        MemReqReady,
    input  logic        MemRespValid,
    input  logic [31:0] MemRespData,
    input  logic        BranchValid,
    input  logic [63:0] BranchTarget,
    output logic        InstValid,
    output logic [63:0] InstAddrOut,
    output logic [31:0] InstOut,
    input  logic        IdReady
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, fcnt_q, fcnt_d;
    logic [AW-1:0] frd_q, frd_d, fwr_q, fwr_d, ard_q, ard_d, awr_q, awr_d;
    logic [63:0]   faddr_q [DEPTH];
    logic [63:0]   faddr_d [DEPTH];
    logic [31:0]   finst_q [DEPTH];
    logic [31:0]   finst_d [DEPTH];
    logic [63:0]   aq_q [DEPTH];
    logic [63:0]   aq_d [DEPTH];
    logic [CW:0]   credit;
    logic          accept, push, pop, dropping;

    always_comb begin
        credit      = {1'b0, inflight_q} + {1'b0, fcnt_q};
        MemReqValid = !rst && !BranchValid && (credit < (CW+1)'(DEPTH));
        MemReqAddr  = pc_q;
        accept      = MemReqValid && MemReqReady;
        // A response in the redirect cycle is stale no matter what drop_q says.
        dropping    = BranchValid || (drop_q != '0);
        push        = MemRespValid && !dropping;
        InstValid   = (fcnt_q != '0) && !BranchValid;
        pop         = InstValid && IdReady;
        InstAddrOut = (fcnt_q != '0) ? faddr_q[frd_q] : 64'h0;
        InstOut     = (fcnt_q != '0) ? finst_q[frd_q] : 32'h0000_0013;
        pc_d        = BranchValid ? {BranchTarget[63:2], 2'b00} : accept ? pc_q + 64'd4 : pc_q;
        inflight_d  = inflight_q + CW'(accept) - CW'(MemRespValid);
        drop_d      = BranchValid ? inflight_q - CW'(MemRespValid)
                                  : drop_q - CW'(MemRespValid && (drop_q != '0));
        fcnt_d      = BranchValid ? '0 : fcnt_q + CW'(push) - CW'(pop);
        frd_d       = BranchValid ? '0 : frd_q + AW'(pop);
        fwr_d       = BranchValid ? '0 : fwr_q + AW'(push);
        // The address queue is never flushed: stale responses still pop their address.
        awr_d       = awr_q + AW'(accept);
        ard_d       = ard_q + AW'(MemRespValid);
        faddr_d     = faddr_q;
        finst_d     = finst_q;
        aq_d        = aq_q;
        if (push) begin
            faddr_d[fwr_q] = aq_q[ard_q];
            finst_d[fwr_q] = MemRespData;
        end
        if (accept) aq_d[awr_q] = pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            fcnt_q     <= '0;
            frd_q      <= '0;
            fwr_q      <= '0;
            ard_q      <= '0;
            awr_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fcnt_q     <= fcnt_d;
            frd_q      <= frd_d;
            fwr_q      <= fwr_d;
            ard_q      <= ard_d;
            awr_q      <= awr_d;
        end
    end

    always_ff @(posedge clk) begin
        faddr_q <= faddr_d;
        finst_q <= finst_d;
        aq_q    <= aq_d;
        if (!rst) assert (!(push && (fcnt_q == CW'(DEPTH))));
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed fetch scenarios against a scoreboard of expected {addr, inst} pairs.
module tb_inst_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst, MemReqValid, MemReqReady, MemRespValid, BranchValid, InstValid, IdReady;
    logic [63:0] MemReqAddr, BranchTarget, InstAddrOut;
    logic [31:0] MemRespData, InstOut;

    logic [63:0] exp_q[$];
    logic [63:0] mem_q[$];
    logic [63:0] exp_pc, hold_addr;
    logic        mem_en;
    int          total = 0, passed = 0, cons = 0, c0;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr), .MemReqReady(MemReqReady),
        .MemRespValid(MemRespValid), .MemRespData(MemRespData),
        .BranchValid(BranchValid), .BranchTarget(BranchTarget),
        .InstValid(InstValid), .InstAddrOut(InstAddrOut), .InstOut(InstOut), .IdReady(IdReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        logic        acc, con;
        logic [63:0] a;
        #1;
        acc = MemReqValid && MemReqReady;
        con = InstValid && IdReady;
        if (rst) begin
            chk("rst_req_valid", 64'(MemReqValid), 64'd0);
            exp_q.delete();
            mem_q.delete();
            exp_pc = RESET_PC;
        end else if (BranchValid) begin
            chk("br_req_valid", 64'(MemReqValid), 64'd0);
            chk("br_inst_valid", 64'(InstValid), 64'd0);
            exp_q.delete();
            exp_pc = {BranchTarget[63:2], 2'b00};
        end else begin
            if (acc) begin
                chk("req_addr", MemReqAddr, exp_pc);
                exp_q.push_back(exp_pc);
                exp_pc += 64'd4;
                mem_q.push_back(MemReqAddr);
            end
            if (con) begin
                a = (exp_q.size() != 0) ? exp_q.pop_front() : ~InstAddrOut;
                chk("out_addr", InstAddrOut, a);
                chk("out_inst", 64'(InstOut), 64'(32'h13 + {24'h0, a[7:0]}));
                cons++;
            end
        end
        @(posedge clk);
        #1;
        if (mem_en && mem_q.size() != 0) begin
            a = mem_q.pop_front();
            MemRespValid = 1'b1;
            MemRespData  = 32'h13 + {24'h0, a[7:0]};
        end else begin
            MemRespValid = 1'b0;
            MemRespData  = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        #1;
        chk({tag, "_inst_valid"}, 64'(InstValid), 64'd0);
        chk({tag, "_inst_addr"}, InstAddrOut, 64'd0);
        chk({tag, "_inst_nop"}, 64'(InstOut), 64'h13);
    endtask

    initial begin
        rst = 1'b1; MemReqReady = 1'b1; MemRespValid = 1'b0; MemRespData = '0;
        BranchValid = 1'b0; BranchTarget = '0; IdReady = 1'b1; mem_en = 1'b1;
        exp_pc = RESET_PC;
        @(negedge clk);
        tick(); tick();
        chk_reset_outputs("reset");
        chk("reset_req_valid", 64'(MemReqValid), 64'd0);

        rst = 1'b0;
        #1;
        chk("first_req_valid", 64'(MemReqValid), 64'd1);
        chk("first_req_addr", MemReqAddr, RESET_PC);
        tick();
        chk("no_bypass", 64'(InstValid), 64'd0);
        tick();
        chk("first_inst_valid", 64'(InstValid), 64'd1);
        chk("first_inst_addr", InstAddrOut, RESET_PC);
        for (int i = 0; i < 10; i++) begin
            chk("stream_no_bubble", 64'(InstValid), 64'd1);
            tick();
        end

        IdReady = 1'b0;
        repeat (10) tick();
        chk("bp_req_dropped", 64'(MemReqValid), 64'd0);
        chk("bp_buffered", 64'(exp_q.size()), 64'd4);
        chk("bp_head_valid", 64'(InstValid), 64'd1);
        IdReady = 1'b1;
        repeat (4) tick();

        MemReqReady = 1'b0;
        hold_addr = exp_pc;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_req_valid", 64'(MemReqValid), 64'd1);
            chk("hold_req_addr", MemReqAddr, hold_addr);
            tick();
        end
        MemReqReady = 1'b1;
        repeat (4) tick();

        mem_en = 1'b0;
        tick(); tick();
        chk("two_in_flight", 64'(mem_q.size()), 64'd2);
        BranchValid = 1'b1;
        BranchTarget = 64'h0000_0000_8000_1002;
        tick();
        BranchValid = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("redir_n1_inst_valid", 64'(InstValid), 64'd0);
        chk("redir_req_valid", 64'(MemReqValid), 64'd1);
        chk("redir_req_addr", MemReqAddr, 64'h0000_0000_8000_1000);
        c0 = cons;
        repeat (3) tick();
        chk("redir_stale_hidden", 64'(InstValid), 64'd0);
        repeat (5) tick();
        chk("redir_drop_zero", 64'(dut.drop_q), 64'd0);
        chk("redir_outputs_seen", 64'(cons != c0), 64'd1);

        chk("pre_coincident_valid", 64'(InstValid), 64'd1);
        chk("pre_coincident_resp", 64'(MemRespValid), 64'd1);
        BranchValid = 1'b1;
        BranchTarget = 64'h0000_0000_8000_2000;
        tick();
        BranchValid = 1'b0;
        chk_reset_outputs("coincident_empty");
        c0 = cons;
        repeat (8) tick();
        chk("coincident_restart", 64'(cons != c0), 64'd1);

        IdReady = 1'b0;
        tick(); tick();
        mem_en = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        chk("midrst_req_valid", 64'(MemReqValid), 64'd0);
        rst = 1'b0;
        mem_en = 1'b1;
        IdReady = 1'b1;
        #1;
        chk("midrst_req_addr", MemReqAddr, RESET_PC);
        c0 = cons;
        repeat (8) tick();
        chk("midrst_restart", 64'(cons != c0), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
